// File: rtl/uart_alu_ctrl_pkg.sv
// Shared definitions for the UART-to-ALU command controller: default widths,
// FSM state encoding and the ALU opcode map used by the controller, the ALU
// and the benches.
package uart_alu_ctrl_pkg;

  localparam int NB_DATA_DEF       = 8;
  localparam int NB_OP_DEF         = 6;
  localparam int TIMEOUT_TICKS_DEF = 4096;

  // Command sequencer states.
  typedef enum logic [2:0] {
    ST_WAIT_A  = 3'd0,
    ST_WAIT_B  = 3'd1,
    ST_WAIT_OP = 3'd2,
    ST_COMPUTE = 3'd3,
    ST_SEND    = 3'd4,
    ST_WAIT_TX = 3'd5
  } state_t;

  // ALU opcodes (low NB_OP bits of the third command byte).
  localparam logic [NB_OP_DEF-1:0] OP_ADD = 6'h20;
  localparam logic [NB_OP_DEF-1:0] OP_SUB = 6'h22;
  localparam logic [NB_OP_DEF-1:0] OP_AND = 6'h24;
  localparam logic [NB_OP_DEF-1:0] OP_OR  = 6'h25;
  localparam logic [NB_OP_DEF-1:0] OP_XOR = 6'h26;
  localparam logic [NB_OP_DEF-1:0] OP_NOR = 6'h27;
  localparam logic [NB_OP_DEF-1:0] OP_SRL = 6'h02;
  localparam logic [NB_OP_DEF-1:0] OP_SRA = 6'h03;

  // States that are collecting command bytes.
  function automatic logic is_wait_state(input state_t s);
    return (s == ST_WAIT_A) || (s == ST_WAIT_B) || (s == ST_WAIT_OP);
  endfunction

  // States in which the block is computing or transmitting a result.
  function automatic logic is_busy_state(input state_t s);
    return (s == ST_COMPUTE) || (s == ST_SEND) || (s == ST_WAIT_TX);
  endfunction

endpackage

// File: rtl/inter_byte_timer.sv
// Saturating inter-byte timeout counter. Counts enable ticks since the last
// clear; tc is asserted combinationally on the tick that would bring the count
// to TICKS, so the owner can act on the same edge. TICKS = 0 disables it.
module inter_byte_timer #(
  parameter int TICKS = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int CW = (TICKS > 0) ? $clog2(TICKS + 1) : 1;
  localparam logic [CW-1:0] MAX_CNT  = (TICKS > 0) ? CW'(TICKS) : '0;
  localparam logic [CW-1:0] LAST_CNT = (TICKS > 0) ? CW'(TICKS - 1) : '0;

  logic [CW-1:0] cnt;

  // Count enabled ticks; clear wins, and the count sticks at MAX_CNT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != MAX_CNT)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Terminal tick: the enabled tick that completes TICKS counts.
  always_comb begin
    tc = (TICKS > 0) && enable && (cnt == LAST_CNT);
  end

endmodule

// File: rtl/uart_alu_ctrl.sv
// UART-to-ALU command controller. Collects operand A, operand B and an opcode
// from the UART receiver, lets the external combinational ALU settle for one
// cycle, hands the result to the UART transmitter and waits for it to finish.
// Handshake: i_rx_done / i_tx_done are single-cycle strobes qualifying the
// data in that cycle; o_tx_start is a single-cycle request with o_tx_data
// already stable in the same cycle; there is no backpressure, so bytes that
// arrive while busy are dropped and flagged through o_err_overrun.
module uart_alu_ctrl
  import uart_alu_ctrl_pkg::*;
#(
  parameter int NB_DATA       = NB_DATA_DEF,
  parameter int NB_OP         = NB_OP_DEF,
  parameter int CHECK_FRAME   = 0,
  parameter int TIMEOUT_TICKS = TIMEOUT_TICKS_DEF
) (
  input  logic               i_clock,
  input  logic               i_reset_n,
  input  logic               i_valid,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_done,
  input  logic               i_rx_frame_valid,
  output logic [NB_DATA-1:0] o_alu_a,
  output logic [NB_DATA-1:0] o_alu_b,
  output logic [NB_OP-1:0]   o_alu_op,
  input  logic [NB_DATA-1:0] i_alu_result,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  input  logic               i_tx_done,
  output logic               o_busy,
  output logic               o_err_timeout,
  output logic               o_err_frame,
  output logic               o_err_overrun,
  output state_t             o_state
);

  state_t state;
  state_t state_next;

  logic rx_ok;
  logic accept;
  logic timer_clear;
  logic timer_en;
  logic timer_tc;

  logic load_a;
  logic load_b;
  logic load_op;
  logic load_tx;
  logic start_d;
  logic err_timeout_d;
  logic err_frame_d;
  logic err_overrun_d;

  // Byte qualification: a byte counts only in a collecting state and, when
  // frame checking is on, only with a good frame status.
  always_comb begin
    rx_ok  = i_rx_done && ((CHECK_FRAME == 0) || i_rx_frame_valid);
    accept = is_wait_state(state) && rx_ok;
  end

  // Timer runs between bytes of a command; restarts on every accepted byte
  // and whenever the FSM returns to WAIT_A.
  always_comb begin
    timer_en    = i_valid && ((state == ST_WAIT_B) || (state == ST_WAIT_OP));
    timer_clear = accept || ((state_next == ST_WAIT_A) && (state != ST_WAIT_A));
  end

  inter_byte_timer #(
    .TICKS(TIMEOUT_TICKS)
  ) u_timer (
    .clk   (i_clock),
    .rst_n (i_reset_n),
    .clear (timer_clear),
    .enable(timer_en),
    .tc    (timer_tc)
  );

  // State register.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= ST_WAIT_A;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; an accepted byte takes priority over the timeout.
  always_comb begin
    state_next = state;
    case (state)
      ST_WAIT_A: begin
        if (accept) state_next = ST_WAIT_B;
      end
      ST_WAIT_B: begin
        if (accept)        state_next = ST_WAIT_OP;
        else if (timer_tc) state_next = ST_WAIT_A;
      end
      ST_WAIT_OP: begin
        if (accept)        state_next = ST_COMPUTE;
        else if (timer_tc) state_next = ST_WAIT_A;
      end
      ST_COMPUTE: state_next = ST_SEND;
      ST_SEND:    state_next = ST_WAIT_TX;
      ST_WAIT_TX: begin
        if (i_tx_done) state_next = ST_WAIT_A;
      end
      default: state_next = ST_WAIT_A;
    endcase
  end

  // Output decode: register load enables and the next value of each pulse.
  // The result is captured on the COMPUTE->SEND edge so that o_tx_data and
  // o_tx_start are both valid throughout the SEND cycle.
  always_comb begin
    load_a        = (state == ST_WAIT_A)  && accept;
    load_b        = (state == ST_WAIT_B)  && accept;
    load_op       = (state == ST_WAIT_OP) && accept;
    load_tx       = (state == ST_COMPUTE);
    start_d       = (state == ST_COMPUTE);
    err_frame_d   = is_wait_state(state) && i_rx_done && !rx_ok;
    err_overrun_d = is_busy_state(state) && i_rx_done;
    err_timeout_d = ((state == ST_WAIT_B) || (state == ST_WAIT_OP)) && timer_tc && !accept;
  end

  // Datapath and pulse registers.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_alu_a       <= '0;
      o_alu_b       <= '0;
      o_alu_op      <= '0;
      o_tx_data     <= '0;
      o_tx_start    <= 1'b0;
      o_err_timeout <= 1'b0;
      o_err_frame   <= 1'b0;
      o_err_overrun <= 1'b0;
    end else begin
      if (load_a)  o_alu_a   <= i_rx_data;
      if (load_b)  o_alu_b   <= i_rx_data;
      if (load_op) o_alu_op  <= i_rx_data[NB_OP-1:0];
      if (load_tx) o_tx_data <= i_alu_result;
      o_tx_start    <= start_d;
      o_err_timeout <= err_timeout_d;
      o_err_frame   <= err_frame_d;
      o_err_overrun <= err_overrun_d;
    end
  end

  // Status outputs decoded straight from the state register.
  always_comb begin
    o_busy  = is_busy_state(state);
    o_state = state;
  end

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Directed bench for uart_alu_ctrl with frame checking on and a 16-tick
// inter-byte timeout. Expected result bytes and their start-pulse cycle are
// queued at issue time; a negedge monitor pops and compares on o_tx_start.
module tb_uart_alu_ctrl;
  import uart_alu_ctrl_pkg::*;

  localparam int W = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          valid = 1'b0;
  logic [W-1:0]  rx_data = '0;
  logic          rx_done = 1'b0;
  logic          rx_frame = 1'b1;
  logic [W-1:0]  alu_a;
  logic [W-1:0]  alu_b;
  logic [5:0]    alu_op;
  logic [W-1:0]  alu_result;
  logic [W-1:0]  tx_data;
  logic          tx_start;
  logic          tx_done = 1'b0;
  logic          busy;
  logic          err_timeout;
  logic          err_frame;
  logic          err_overrun;
  state_t        st;
  logic          op_flag = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  int neg_idx = 0;
  int ts_cnt = 0, to_cnt = 0, fr_cnt = 0, ov_cnt = 0;
  logic prev_ts = 0, prev_to = 0, prev_fr = 0, prev_ov = 0;

  logic [W-1:0] exp_q[$];
  int           lat_q[$];

  // clock / reset
  always #5 clk = ~clk;

  uart_alu_ctrl #(
    .NB_DATA(8), .NB_OP(6), .CHECK_FRAME(1), .TIMEOUT_TICKS(16)
  ) dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_valid(valid),
    .i_rx_data(rx_data), .i_rx_done(rx_done), .i_rx_frame_valid(rx_frame),
    .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_op(alu_op),
    .i_alu_result(alu_result), .o_tx_data(tx_data), .o_tx_start(tx_start),
    .i_tx_done(tx_done), .o_busy(busy), .o_err_timeout(err_timeout),
    .o_err_frame(err_frame), .o_err_overrun(err_overrun), .o_state(st)
  );

  // combinational ALU model
  always_comb begin
    alu_result = '0;
    case (alu_op)
      OP_ADD: alu_result = alu_a + alu_b;
      OP_SUB: alu_result = alu_a - alu_b;
      OP_AND: alu_result = alu_a & alu_b;
      OP_OR:  alu_result = alu_a | alu_b;
      default: alu_result = '0;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    neg_idx++;
    if (rst_n) begin
      if (rx_done && op_flag) lat_q.push_back(neg_idx + 2);
      if (tx_start) begin
        ts_cnt++;
        check("tx_start_width", {31'b0, prev_ts}, 32'd0);
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL tx_start_unexpected: got data 0x%0h, expected no pulse", tx_data);
        end else begin
          check("tx_data", {24'b0, tx_data}, {24'b0, exp_q.pop_front()});
        end
        if (lat_q.size() != 0) check("tx_start_latency", neg_idx, lat_q.pop_front());
      end
      if (err_timeout) begin to_cnt++; check("err_timeout_width", {31'b0, prev_to}, 32'd0); end
      if (err_frame)   begin fr_cnt++; check("err_frame_width",   {31'b0, prev_fr}, 32'd0); end
      if (err_overrun) begin ov_cnt++; check("err_overrun_width", {31'b0, prev_ov}, 32'd0); end
    end
    prev_ts = tx_start; prev_to = err_timeout; prev_fr = err_frame; prev_ov = err_overrun;
  end

  // driver tasks
  task automatic settle();
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [W-1:0] b, input logic fv, input logic tick, input logic is_op);
    @(posedge clk); #1;
    rx_data = b; rx_frame = fv; rx_done = 1'b1; valid = tick; op_flag = is_op;
    @(posedge clk); #1;
    rx_done = 1'b0; valid = 1'b0; op_flag = 1'b0; rx_frame = 1'b1;
  endtask

  task automatic send_cmd(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [5:0] op, input logic [W-1:0] exp);
    exp_q.push_back(exp);
    send_byte(a, 1'b1, 1'b0, 1'b0);
    send_byte(b, 1'b1, 1'b0, 1'b0);
    send_byte({2'b00, op}, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic tick();
    @(posedge clk); #1 valid = 1'b1;
    @(posedge clk); #1 valid = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic pulse_tx_done();
    @(posedge clk); #1 tx_done = 1'b1;
    @(posedge clk); #1 tx_done = 1'b0;
  endtask

  task automatic wait_tx_start();
    int start;
    start = ts_cnt;
    for (int i = 0; i < 20; i++) begin
      settle();
      if (ts_cnt != start) break;
    end
    check("tx_start_seen", ts_cnt - start, 1);
  endtask

  task automatic complete_tx();
    wait_tx_start();
    repeat (2) settle();
    check("busy_in_wait_tx", {31'b0, busy}, 32'd1);
    pulse_tx_done();
    check("busy_after_tx_done", {31'b0, busy}, 32'd0);
    check("state_after_tx_done", 32'(st), 32'(ST_WAIT_A));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, 32'(st), 32'(ST_WAIT_A));
    check({tag, "_alu_a"}, {24'b0, alu_a}, 32'd0);
    check({tag, "_alu_b"}, {24'b0, alu_b}, 32'd0);
    check({tag, "_alu_op"}, {26'b0, alu_op}, 32'd0);
    check({tag, "_tx_data"}, {24'b0, tx_data}, 32'd0);
    check({tag, "_pulses"}, {27'b0, tx_start, busy, err_timeout, err_frame, err_overrun}, 32'd0);
  endtask

  task automatic report();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
  endtask

  // watchdog
  initial begin
    #500000;
    n_tests++; n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    report();
    $finish;
  end

  initial begin
    int ts_before;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset");
    @(negedge clk) rst_n = 1'b1;

    // basic ADD: 5 + 3
    send_cmd(8'h05, 8'h03, OP_ADD, 8'h08);
    complete_tx();

    // timeout after A, then SUB 10 - 4
    send_byte(8'h05, 1'b1, 1'b0, 1'b0);
    check("state_after_a", 32'(st), 32'(ST_WAIT_B));
    repeat (15) tick();
    settle();
    check("state_tick15", 32'(st), 32'(ST_WAIT_B));
    check("no_timeout_tick15", to_cnt, 0);
    tick();
    settle();
    check("timeout_tick16", to_cnt, 1);
    check("state_after_timeout", 32'(st), 32'(ST_WAIT_A));
    check("alu_a_kept", {24'b0, alu_a}, 32'h05);
    check("alu_b_kept", {24'b0, alu_b}, 32'h03);
    send_cmd(8'h0A, 8'h04, OP_SUB, 8'h06);
    complete_tx();

    // byte on the terminal tick wins; AND 0x0C & 0x0A
    exp_q.push_back(8'h08);
    send_byte(8'h0C, 1'b1, 1'b0, 1'b0);
    repeat (15) tick();
    send_byte(8'h0A, 1'b1, 1'b1, 1'b0);
    settle();
    check("coincide_state", 32'(st), 32'(ST_WAIT_OP));
    check("coincide_no_timeout", to_cnt, 1);
    send_byte({2'b00, OP_AND}, 1'b1, 1'b0, 1'b1);
    complete_tx();

    // frame error on B, resend; OR 0x0C | 0x03
    exp_q.push_back(8'h0F);
    send_byte(8'h0C, 1'b1, 1'b0, 1'b0);
    send_byte(8'h55, 1'b0, 1'b0, 1'b0);
    settle();
    check("frame_err_pulse", fr_cnt, 1);
    check("frame_err_state", 32'(st), 32'(ST_WAIT_B));
    check("frame_err_alu_b", {24'b0, alu_b}, 32'h0A);
    send_byte(8'h03, 1'b1, 1'b0, 1'b0);
    send_byte({2'b00, OP_OR}, 1'b1, 1'b0, 1'b1);
    complete_tx();

    // overrun in WAIT_TX; ADD 7 + 2
    send_cmd(8'h07, 8'h02, OP_ADD, 8'h09);
    wait_tx_start();
    send_byte(8'hEE, 1'b1, 1'b0, 1'b0);
    settle();
    check("overrun_pulse", ov_cnt, 1);
    check("overrun_tx_data", {24'b0, tx_data}, 32'h09);
    check("overrun_state", 32'(st), 32'(ST_WAIT_TX));
    pulse_tx_done();
    check("overrun_then_done", 32'(st), 32'(ST_WAIT_A));

    // tx_done and rx_done in the same WAIT_TX cycle; ADD 1 + 1
    send_cmd(8'h01, 8'h01, OP_ADD, 8'h02);
    wait_tx_start();
    @(posedge clk); #1;
    rx_data = 8'h33; rx_done = 1'b1; tx_done = 1'b1;
    @(posedge clk); #1;
    rx_done = 1'b0; tx_done = 1'b0;
    settle();
    check("coincide_done_state", 32'(st), 32'(ST_WAIT_A));
    check("coincide_done_overrun", ov_cnt, 2);
    check("coincide_done_alu_a", {24'b0, alu_a}, 32'h01);

    // tx_done outside WAIT_TX ignored; ADD 0x11 + 0x22
    exp_q.push_back(8'h33);
    send_byte(8'h11, 1'b1, 1'b0, 1'b0);
    pulse_tx_done();
    check("stray_tx_done_state", 32'(st), 32'(ST_WAIT_B));
    send_byte(8'h22, 1'b1, 1'b0, 1'b0);
    send_byte({2'b00, OP_ADD}, 1'b1, 1'b0, 1'b1);
    complete_tx();

    // asynchronous reset in WAIT_OP
    send_byte(8'h01, 1'b1, 1'b0, 1'b0);
    send_byte(8'h02, 1'b1, 1'b0, 1'b0);
    check("pre_reset_state", 32'(st), 32'(ST_WAIT_OP));
    ts_before = ts_cnt;
    @(posedge clk); #3 rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (6) settle();
    check("no_start_after_reset", ts_cnt, ts_before);
    check("state_after_reset", 32'(st), 32'(ST_WAIT_A));
    send_cmd(8'h09, 8'h03, OP_SUB, 8'h06);
    complete_tx();

    // final tallies
    check("timeout_total", to_cnt, 1);
    check("frame_total", fr_cnt, 1);
    check("overrun_total", ov_cnt, 2);
    check("exp_q_empty", exp_q.size(), 0);

    report();
    $finish;
  end

endmodule
